// File: rtl/qspi_pkg.sv
// Shared constants and state encoding for the quad-SPI flash read controller.
// Mode-bit selection for continuous read is made in the top under QSPI_CONT_READ_EN.
package qspi_pkg;

    localparam logic [7:0] CMD_QUAD_READ = 8'hEB;
    localparam logic [7:0] MODE_NO_CONT  = 8'hFF;
    localparam logic [7:0] MODE_CONT     = 8'hA0;

    // Phase lengths in SCK cycles
    localparam int CMD_LEN   = 8;
    localparam int ADDR_LEN  = 6;
    localparam int MODE_LEN  = 2;
    localparam int DUMMY_LEN = 4;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        MODE,
        DUMMY,
        DATA,
        STALLED
    } state_t;

    function automatic logic [2:0] last_cnt(input state_t st);
        case (st)
            CMD:     last_cnt = 3'(CMD_LEN - 1);
            ADDR:    last_cnt = 3'(ADDR_LEN - 1);
            MODE:    last_cnt = 3'(MODE_LEN - 1);
            DUMMY:   last_cnt = 3'(DUMMY_LEN - 1);
            default: last_cnt = 3'd0;
        endcase
    endfunction

    function automatic state_t next_phase(input state_t st);
        case (st)
            CMD:     next_phase = ADDR;
            ADDR:    next_phase = MODE;
            MODE:    next_phase = DUMMY;
            DUMMY:   next_phase = DATA;
            default: next_phase = IDLE;
        endcase
    endfunction

endpackage

// File: rtl/qspi_flash_ctrl.sv
// Read-only quad-SPI flash master streaming sequential words via Fast Read Quad I/O.
// Define QSPI_CONT_READ_EN to use continuous-read mode and skip the command after the first burst.
module qspi_flash_ctrl
    import qspi_pkg::*;
#(
    parameter int DATA_WIDTH_BYTES = 1,
    parameter int ADDR_BITS        = 24
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [3:0]                    spi_data_in,
    output logic [3:0]                    spi_data_out,
    output logic [3:0]                    spi_data_oe,
    output logic                          spi_select,
    output logic                          spi_clk_out,
    input  logic [ADDR_BITS-1:0]          addr_in,
    input  logic                          start_read,
    input  logic                          stall_read,
    input  logic                          stop_read,
    output logic [8*DATA_WIDTH_BYTES-1:0] data_out,
    output logic                          data_ready,
    output logic                          busy
);

    localparam int NIBS = 2 * DATA_WIDTH_BYTES;
    localparam int NW   = $clog2(NIBS + 1);
    localparam int DW   = 8 * DATA_WIDTH_BYTES;

`ifdef QSPI_CONT_READ_EN
    localparam logic [7:0] MODE_BITS = MODE_CONT;
    localparam logic       CONT_EN   = 1'b1;
`else
    localparam logic [7:0] MODE_BITS = MODE_NO_CONT;
    localparam logic       CONT_EN   = 1'b0;
`endif

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [NW-1:0]   nib_q, nib_d;
    logic [23:0]     addr_q, addr_d;
    logic [DW-1:0]   word_q, word_d;
    logic            cont_q, cont_d;
    logic [3:0]      sdo_d, oe_d;
    logic            sel_d, sck_d, drdy_d, busy_d;
    logic [DW-1:0]   dout_d;
    logic [23:0]     addr_w;
    int              pos;

    assign addr_w = 24'(addr_in);

    // Nibble presented on the bus for position c of phase st
    function automatic logic [3:0] tx_nibble(input state_t st, input logic [2:0] c,
                                             input logic [23:0] a);
        case (st)
            CMD:     tx_nibble = {3'b000, CMD_QUAD_READ[7 - int'(c)]};
            ADDR:    tx_nibble = a[(5 - int'(c)) * 4 +: 4];
            MODE:    tx_nibble = MODE_BITS[(1 - int'(c)) * 4 +: 4];
            default: tx_nibble = 4'h0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nib_d   = nib_q;
        addr_d  = addr_q;
        word_d  = word_q;
        cont_d  = cont_q;
        sdo_d   = spi_data_out;
        oe_d    = spi_data_oe;
        sel_d   = spi_select;
        sck_d   = spi_clk_out;
        dout_d  = data_out;
        drdy_d  = data_ready;
        busy_d  = busy;
        pos     = 0;

        if (busy && stop_read) begin
            state_d = IDLE;
            sel_d   = 1'b1;
            sck_d   = 1'b0;
            oe_d    = 4'b0000;
            sdo_d   = 4'h0;
            busy_d  = 1'b0;
            drdy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_read) begin
                        addr_d = addr_w;
                        sel_d  = 1'b0;
                        busy_d = 1'b1;
                        sck_d  = 1'b0;
                        cnt_d  = 3'd0;
                        nib_d  = '0;
                        if (cont_q) begin
                            state_d = ADDR;
                            oe_d    = 4'b1111;
                            sdo_d   = tx_nibble(ADDR, 3'd0, addr_w);
                        end else begin
                            state_d = CMD;
                            oe_d    = 4'b0001;
                            sdo_d   = tx_nibble(CMD, 3'd0, addr_w);
                        end
                    end
                end
                STALLED: begin
                    if (!stall_read) state_d = DATA;
                end
                default: begin
                    sck_d = ~spi_clk_out;
                    if (!spi_clk_out) begin
                        // Rising SCK: sample flash data, high nibble of each byte first
                        if (state_q == DATA) begin
                            pos    = 8 * int'(nib_q >> 1) + (nib_q[0] ? 0 : 4);
                            word_d[pos +: 4] = spi_data_in;
                            nib_d  = nib_q + 1'b1;
                            drdy_d = 1'b0;
                        end
                    end else if (state_q == DATA) begin
                        if (nib_q == NW'(NIBS)) begin
                            dout_d = word_q;
                            drdy_d = 1'b1;
                            nib_d  = '0;
                            if (stall_read) state_d = STALLED;
                        end
                    end else if (cnt_q == last_cnt(state_q)) begin
                        cnt_d   = 3'd0;
                        state_d = next_phase(state_q);
                        if (state_q == CMD) cont_d = CONT_EN;
                        oe_d    = (state_d == ADDR || state_d == MODE) ? 4'b1111 : 4'b0000;
                        sdo_d   = tx_nibble(state_d, 3'd0, addr_q);
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        sdo_d = tx_nibble(state_q, cnt_d, addr_q);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            nib_q        <= '0;
            addr_q       <= 24'd0;
            word_q       <= '0;
            cont_q       <= 1'b0;
            spi_data_out <= 4'h0;
            spi_data_oe  <= 4'b0000;
            spi_select   <= 1'b1;
            spi_clk_out  <= 1'b0;
            data_out     <= '0;
            data_ready   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            nib_q        <= nib_d;
            addr_q       <= addr_d;
            word_q       <= word_d;
            cont_q       <= cont_d;
            spi_data_out <= sdo_d;
            spi_data_oe  <= oe_d;
            spi_select   <= sel_d;
            spi_clk_out  <= sck_d;
            data_out     <= dout_d;
            data_ready   <= drdy_d;
            busy         <= busy_d;
        end
    end

endmodule

// File: tb/tb_qspi_flash_ctrl.sv
// Directed bench for qspi_flash_ctrl with a behavioural quad-I/O flash model.
// Honours QSPI_CONT_READ_EN when the design is built with it.
module tb_qspi_flash_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  spi_data_in;
    logic [3:0]  spi_data_out, spi_data_oe;
    logic        spi_select, spi_clk_out;
    logic [23:0] addr_in;
    logic        start_read, stall_read, stop_read;
    logic [7:0]  data_out;
    logic        data_ready, busy;

    int checks = 0;
    int errors = 0;
    bit cont   = 1'b0;

`ifdef QSPI_CONT_READ_EN
    localparam logic [7:0] MODE_EXP = 8'hA0;
`else
    localparam logic [7:0] MODE_EXP = 8'hFF;
`endif

    qspi_flash_ctrl #(.DATA_WIDTH_BYTES(1), .ADDR_BITS(24)) dut (
        .clk(clk), .rstn(rstn), .spi_data_in(spi_data_in), .spi_data_out(spi_data_out),
        .spi_data_oe(spi_data_oe), .spi_select(spi_select), .spi_clk_out(spi_clk_out),
        .addr_in(addr_in), .start_read(start_read), .stall_read(stall_read),
        .stop_read(stop_read), .data_out(data_out), .data_ready(data_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Flash model: observes the bus mid-cycle, captures cmd/addr/mode, serves data bytes
    logic [7:0]  m_cmd, m_mode;
    logic [23:0] m_addr;
    int          m_rise;
    bit          m_cont, m_mode_done, m_oe_err;
    logic        prev_sck, prev_cs;
    logic [7:0]  m_data [4] = '{8'h5A, 8'hC3, 8'h96, 8'h3C};

    always @(negedge clk) begin
        int p, j;
        logic [7:0] b;
        if (!rstn) begin
            m_cont = 0; prev_sck = 0; prev_cs = 1; spi_data_in = 4'h0;
            m_rise = 0; m_mode_done = 0; m_oe_err = 0;
        end else begin
            if (prev_cs && !spi_select) begin
                m_rise = 0; m_cmd = 0; m_addr = 0; m_mode = 0; m_mode_done = 0; m_oe_err = 0;
            end
            if (!prev_cs && spi_select && m_mode_done) m_cont = (m_mode == 8'hA0);
            if (!spi_select && !prev_sck && spi_clk_out) begin
                m_rise++;
                p = m_cont ? m_rise + 8 : m_rise;
                if (p <= 8) begin
                    m_cmd = {m_cmd[6:0], spi_data_out[0]};
                    if (spi_data_oe !== 4'b0001) m_oe_err = 1;
                end else if (p <= 14) begin
                    m_addr = {m_addr[19:0], spi_data_out};
                    if (spi_data_oe !== 4'b1111) m_oe_err = 1;
                end else if (p <= 16) begin
                    m_mode = {m_mode[3:0], spi_data_out};
                    if (spi_data_oe !== 4'b1111) m_oe_err = 1;
                    if (p == 16) m_mode_done = 1;
                end else if (spi_data_oe !== 4'b0000) m_oe_err = 1;
            end
            if (!spi_select && prev_sck && !spi_clk_out) begin
                p = (m_cont ? m_rise + 8 : m_rise) + 1;
                if (p >= 21) begin
                    j = p - 21;
                    b = m_data[(j / 2) % 4];
                    spi_data_in = (j % 2 == 0) ? b[7:4] : b[3:0];
                end
            end
            prev_sck = spi_clk_out;
            prev_cs  = spi_select;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [23:0] a);
        addr_in = a; start_read = 1'b1;
        tick();
        start_read = 1'b0;
    endtask

    task automatic do_stop;
        stop_read = 1'b1;
        tick();
        stop_read = 1'b0;
    endtask

    function automatic int lat();
        return cont ? 28 : 44;
    endfunction

    task automatic test_reset;
        rstn = 1'b0; start_read = 0; stall_read = 0; stop_read = 0; addr_in = 0;
        repeat (3) tick();
        checks++;
        if ({spi_select, spi_clk_out, spi_data_oe, spi_data_out, busy, data_ready, data_out}
            !== {1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_hold observed sel=%b sck=%b oe=%h do=%h busy=%b rdy=%b dout=%h",
                     spi_select, spi_clk_out, spi_data_oe, spi_data_out, busy, data_ready, data_out);
        end
        rstn = 1'b1;
        tick();
        checks++;
        if ({spi_select, spi_clk_out, spi_data_oe, busy, data_ready} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_release observed sel=%b sck=%b oe=%h busy=%b rdy=%b",
                     spi_select, spi_clk_out, spi_data_oe, busy, data_ready);
        end
    endtask

    task automatic test_read;
        start(24'h100123);
        checks++;
        if ({spi_select, busy, spi_clk_out, spi_data_oe} !== {1'b0, 1'b1, 1'b0, (cont ? 4'b1111 : 4'b0001)}) begin
            errors++;
            $display("FAIL read_start observed sel=%b busy=%b sck=%b oe=%b", spi_select, busy, spi_clk_out, spi_data_oe);
        end
        repeat (lat() - 1) tick();
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL read_early_ready observed %b expected 0", data_ready); end
        tick();
        checks++;
        if ({data_ready, data_out} !== {1'b1, 8'h5A}) begin
            errors++; $display("FAIL read_word0 observed rdy=%b dout=%h expected 1 5a", data_ready, data_out);
        end
        repeat (3) tick();
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL read_ready_drop observed %b expected 0", data_ready); end
        tick();
        checks++;
        if ({data_ready, data_out} !== {1'b1, 8'hC3}) begin
            errors++; $display("FAIL read_word1 observed rdy=%b dout=%h expected 1 c3", data_ready, data_out);
        end
        if (!cont) begin
            checks++;
            if (m_cmd !== 8'hEB) begin errors++; $display("FAIL read_cmd observed %h expected eb", m_cmd); end
        end
        checks++;
        if ({m_addr, m_mode, m_oe_err} !== {24'h100123, MODE_EXP, 1'b0}) begin
            errors++; $display("FAIL read_header observed addr=%h mode=%h oe_err=%b expected 100123 %h 0",
                               m_addr, m_mode, m_oe_err, MODE_EXP);
        end
        do_stop();
        checks++;
        if ({spi_select, busy, data_ready, spi_clk_out, spi_data_oe, data_out}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'hC3}) begin
            errors++; $display("FAIL read_stop observed sel=%b busy=%b rdy=%b sck=%b oe=%h dout=%h",
                               spi_select, busy, data_ready, spi_clk_out, spi_data_oe, data_out);
        end
`ifdef QSPI_CONT_READ_EN
        cont = 1'b1;
`endif
    endtask

    task automatic test_stall;
        stall_read = 1'b1;
        start(24'h100123);
        repeat (lat()) tick();
        checks++;
        if ({data_ready, data_out} !== {1'b1, 8'h5A}) begin
            errors++; $display("FAIL stall_word0 observed rdy=%b dout=%h expected 1 5a", data_ready, data_out);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({data_ready, spi_clk_out, spi_select, busy, data_out} !== {1'b1, 1'b0, 1'b0, 1'b1, 8'h5A}) begin
                errors++; $display("FAIL stall_hold cycle %0d observed rdy=%b sck=%b sel=%b busy=%b dout=%h",
                                   i, data_ready, spi_clk_out, spi_select, busy, data_out);
            end
        end
        stall_read = 1'b0;
        repeat (4) tick();
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL stall_resume_early observed %b expected 0", data_ready); end
        tick();
        checks++;
        if ({data_ready, data_out} !== {1'b1, 8'hC3}) begin
            errors++; $display("FAIL stall_resume observed rdy=%b dout=%h expected 1 c3", data_ready, data_out);
        end
        do_stop();
    endtask

    task automatic test_stop_addr;
        start(24'h100123);
        repeat (cont ? 3 : 19) tick();
        checks++;
        if (spi_data_oe !== 4'b1111) begin errors++; $display("FAIL stop_in_addr_phase observed oe=%b expected 1111", spi_data_oe); end
        do_stop();
        checks++;
        if ({spi_select, busy, spi_clk_out, spi_data_oe} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
            errors++; $display("FAIL stop_addr observed sel=%b busy=%b sck=%b oe=%h", spi_select, busy, spi_clk_out, spi_data_oe);
        end
        start(24'h000FFF);
        checks++;
        if (spi_data_oe !== (cont ? 4'b1111 : 4'b0001)) begin
            errors++; $display("FAIL restart_oe observed %b expected %b", spi_data_oe, (cont ? 4'b1111 : 4'b0001));
        end
        repeat (lat()) tick();
        checks++;
        if ({data_ready, data_out, m_addr} !== {1'b1, 8'h5A, 24'h000FFF}) begin
            errors++; $display("FAIL restart_word observed rdy=%b dout=%h addr=%h expected 1 5a 000fff",
                               data_ready, data_out, m_addr);
        end
        if (!cont) begin
            checks++;
            if (m_cmd !== 8'hEB) begin errors++; $display("FAIL restart_cmd observed %h expected eb", m_cmd); end
        end
        do_stop();
    endtask

    task automatic test_busy_ignore;
        start(24'h100123);
        repeat (3) tick();
        addr_in = 24'hABCDEF; start_read = 1'b1;
        tick();
        start_read = 1'b0;
        checks++;
        if ({busy, spi_select} !== {1'b1, 1'b0}) begin
            errors++; $display("FAIL busy_start_ignored observed busy=%b sel=%b", busy, spi_select);
        end
        repeat (lat() - 4) tick();
        checks++;
        if ({data_ready, data_out, m_addr} !== {1'b1, 8'h5A, 24'h100123}) begin
            errors++; $display("FAIL busy_keep_addr observed rdy=%b dout=%h addr=%h expected 1 5a 100123",
                               data_ready, data_out, m_addr);
        end
        stop_read = 1'b1; start_read = 1'b1; addr_in = 24'h000FFF;
        tick();
        stop_read = 1'b0; start_read = 1'b0;
        checks++;
        if ({busy, spi_select} !== {1'b0, 1'b1}) begin
            errors++; $display("FAIL stop_wins observed busy=%b sel=%b expected 0 1", busy, spi_select);
        end
        tick();
        checks++;
        if ({busy, spi_select} !== {1'b0, 1'b1}) begin
            errors++; $display("FAIL stop_wins_after observed busy=%b sel=%b expected 0 1", busy, spi_select);
        end
    endtask

    task automatic test_async_reset;
        start(24'h100123);
        repeat (10) tick();
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({spi_select, busy, spi_clk_out, spi_data_oe, data_ready, data_out}
            !== {1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00}) begin
            errors++; $display("FAIL async_reset observed sel=%b busy=%b sck=%b oe=%h rdy=%b dout=%h",
                               spi_select, busy, spi_clk_out, spi_data_oe, data_ready, data_out);
        end
        tick();
        rstn = 1'b1;
        cont = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_stall();
        test_stop_addr();
        test_busy_ignore();
        test_async_reset();
        test_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qspi_flash_ctrl.md
Name: qspi_flash_ctrl

Overview:
- Read-only quad-SPI flash master that streams sequential bytes from a 24-bit flash address, using Fast Read Quad I/O (command 0xEB).
- Sits between the cartridge ROM fetch logic and the external QSPI PMOD flash.
- Supports stall, which holds a ready word and pauses SCK, and stop, which ends the burst.

Parameters:
- DATA_WIDTH_BYTES, 1, bytes per data_out word.
- ADDR_BITS, 24, width of addr_in. The address is zero-extended or truncated to 24 bits on the wire.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- spi_data_in  in  4  IO3..IO0 from flash
- spi_data_out  out  4  IO3..IO0 to flash
- spi_data_oe  out  4  per-line output enable, 1 = drive
- spi_select  out  1  flash CS#, active low
- spi_clk_out  out  1  SCK
- addr_in  in  ADDR_BITS  start byte address, sampled on an accepted start_read
- start_read  in  1  begin burst; honoured only when busy=0
- stall_read  in  1  pause after the current word completes
- stop_read  in  1  abort the burst
- data_out  out  8*DATA_WIDTH_BYTES  last complete word
- data_ready  out  1  data_out holds a fresh word
- busy  out  1  transaction in progress

Behaviour:
- Reset values: spi_select=1, spi_clk_out=0, spi_data_oe=0000, spi_data_out=0000, data_out=0, data_ready=0, busy=0, FSM=IDLE.
- All outputs are registered.
- FSM states: IDLE, CMD, ADDR, MODE, DUMMY, DATA, STALLED.
- SCK runs at clk/2:
  - While in CMD through DATA, spi_clk_out toggles every clk.
  - Outputs change only while SCK is low.
  - Input is sampled on the clk edge that raises SCK.
- IDLE + start_read at cycle N:
  - Latch the address.
  - At N+1: spi_select=0, busy=1, first command bit driven, SCK=0.
  - SCK rising edges occur at N+2, N+4, …
- CMD phase: 8 SCK cycles, 0xEB MSB first on IO0, oe=0001.
- ADDR phase: 6 SCK cycles, address MSB nibble first, oe=1111.
- MODE phase: 2 SCK cycles, nibbles F,F (0xFF = no continuous mode), oe=1111.
- DUMMY phase: 4 SCK cycles, oe=0000.
- DATA phase:
  - oe=0000; one nibble per rising SCK, high nibble of each byte first.
  - Byte k of a word goes to data_out[8k+7:8k].
- Word completion:
  - When 2*DATA_WIDTH_BYTES nibbles are assembled, data_out updates and data_ready=1 on the next clk.
  - First word: data_ready=1 at cycle N+45 (22 rising SCK edges; the last one at N+44).
- data_ready stays 1 until the first nibble of the following word is sampled, then drops to 0.
- data_out is stable whenever data_ready=1.
- Stall:
  - If stall_read=1 when a word completes, enter STALLED: SCK held low, select held low, busy stays 1, data_ready stays 1.
  - Resume clocking on the cycle after stall_read falls.
  - stall_read is ignored in all other phases.
- Stop:
  - stop_read while busy, in any phase, takes effect the next clk: spi_select=1, SCK=0, oe=0000, busy=0, FSM=IDLE.
  - data_out is kept; data_ready is cleared.
  - stop_read wins over a simultaneous start_read.
- start_read while busy is ignored.
- The address auto-increments inside the flash; no internal address counter is needed.
- Asynchronous reset mid-transaction returns immediately to the reset values.

Optional Feature:
- Macro: QSPI_CONT_READ_EN.
- Defined:
  - MODE nibbles are A,0 (0xA0), so the flash enters continuous-read mode.
  - Every start_read after the first completed CMD skips the CMD phase (first data_ready at N+29).
  - Reset clears the "continuous mode active" flag, so the first transaction always sends the command.
- Undefined: MODE is 0xFF and the command is sent on every transaction.

Decomposition:
- Shared package qspi_pkg:
  - Command constant 0xEB and mode constants 0xFF / 0xA0.
  - Phase lengths in SCK cycles: CMD 8, ADDR 6, MODE 2, DUMMY 4.
  - FSM state enum.
- Single module, no sub-module required; a nibble counter and a shift register suffice.

Test Plan:
- Reset: hold rstn=0, then release -> select=1, SCK=0, oe=0, busy=0, data_ready=0.
- Read of address 0x100123 with flash model returning 0x5A then 0xC3:
  - The flash model sees 0xEB, address 100123, mode FF.
  - data_ready rises at N+45 with data_out=0x5A.
  - Next word 0xC3 arrives 4 clk later.
- Stall: stall_read=1 before the first word ->
  - data_ready=1 and data_out=0x5A held for 20 cycles, SCK frozen low.
  - Release -> 0xC3 delivered 5 clk after stall_read falls.
- Stop during ADDR phase: stop_read=1 -> next clk select=1, busy=0.
  - A new start_read to 0x000FFF restarts with a full command.
- start_read while busy is ignored; simultaneous stop_read + start_read while busy -> stop only, busy=0.
- With QSPI_CONT_READ_EN:
  - The first transaction sends mode A0.
  - The second transaction has no CMD phase and first data_ready at N+29.
